grid_write_arbiter: RTL and testbench

//  Shares the 8x8 colour-grid write port (cell x/y, write enable, r/g/b) between two requesters
//  (req0: game logic, req1: player/cursor logic). Round-robin arbitration.

---
 rtl/grid_write_arbiter_if.sv | 30 +++
 rtl/grid_write_arbiter.sv | 117 +++++++++++
 tb/tb_grid_write_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/grid_write_arbiter_if.sv
// grid_write_arbiter_if: bundles the requester, clear and grid-write signals of the write arbiter
interface grid_write_arbiter_if;
   logic        i_clear_req;
   logic        o_clear_busy;
   logic        i_req0;
   logic [3:0]  i_x0;
   logic [3:0]  i_y0;
   logic [23:0] i_col0;
   logic        o_ack0;
   logic        i_req1;
   logic [3:0]  i_x1;
   logic [3:0]  i_y1;
   logic [23:0] i_col1;
   logic        o_ack1;
   logic        o_err;
   logic [3:0]  o_wr_x;
   logic [3:0]  o_wr_y;
   logic        o_wr_en;
   logic [7:0]  o_wr_r;
   logic [7:0]  o_wr_g;
   logic [7:0]  o_wr_b;
   modport master (
      output i_clear_req, i_req0, i_x0, i_y0, i_col0, i_req1, i_x1, i_y1, i_col1,
      input  o_clear_busy, o_ack0, o_ack1, o_err, o_wr_x, o_wr_y, o_wr_en, o_wr_r, o_wr_g, o_wr_b
   );
   modport slave (
      input  i_clear_req, i_req0, i_x0, i_y0, i_col0, i_req1, i_x1, i_y1, i_col1,
      output o_clear_busy, o_ack0, o_ack1, o_err, o_wr_x, o_wr_y, o_wr_en, o_wr_r, o_wr_g, o_wr_b
   );
endinterface

// File: rtl/grid_write_arbiter.sv
// grid_write_arbiter: round-robin sharing of the colour-grid write port with a full-grid clear sweep
module grid_write_arbiter #(
   parameter int         GRID_W = 8,
   parameter int         GRID_H = 8,
   parameter logic [7:0] CLR_R  = 8'h53,
   parameter logic [7:0] CLR_G  = 8'h56,
   parameter logic [7:0] CLR_B  = 8'h5B
) (
   input logic                 clk,
   input logic                 rst,
   grid_write_arbiter_if.slave bus
);
   localparam logic [4:0] W_LIM  = 5'(GRID_W);
   localparam logic [4:0] H_LIM  = 5'(GRID_H);
   localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
   localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);
   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
   state_t      r_state;
   logic        r_ptr;
   logic        r_ack0;
   logic        r_ack1;
   logic        r_err;
   logic        r_busy;
   logic        r_wr_en;
   logic [3:0]  r_wr_x;
   logic [3:0]  r_wr_y;
   logic [23:0] r_wr_col;
   logic        w_any;
   logic        w_gnt;
   logic        w_ok;
   logic [3:0]  w_x;
   logic [3:0]  w_y;
   logic [23:0] w_col;
   // grant selection: alternate on contention, otherwise whichever requester is asking
   always_comb begin
      w_any = bus.i_req0 | bus.i_req1;
      w_gnt = (bus.i_req0 & bus.i_req1) ? r_ptr : bus.i_req1;
      w_x   = w_gnt ? bus.i_x1 : bus.i_x0;
      w_y   = w_gnt ? bus.i_y1 : bus.i_y0;
      w_col = w_gnt ? bus.i_col1 : bus.i_col0;
      w_ok  = ({1'b0, w_x} < W_LIM) && ({1'b0, w_y} < H_LIM);
   end
   // control FSM with registered outputs; the write cell registers double as the sweep counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_ptr    <= 1'b0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_err    <= 1'b0;
         r_busy   <= 1'b0;
         r_wr_en  <= 1'b0;
         r_wr_x   <= '0;
         r_wr_y   <= '0;
         r_wr_col <= '0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.i_clear_req) begin
                  r_state  <= CLEAR;
                  r_busy   <= 1'b1;
                  r_wr_en  <= 1'b1;
                  r_wr_x   <= '0;
                  r_wr_y   <= '0;
                  r_wr_col <= {CLR_R, CLR_G, CLR_B};
               end else if (w_any) begin
                  r_state <= WRITE;
                  r_ptr   <= ~w_gnt;
                  r_ack0  <= ~w_gnt;
                  r_ack1  <= w_gnt;
                  r_err   <= ~w_ok;
                  r_wr_en <= w_ok;
                  if (w_ok) begin
                     r_wr_x   <= w_x;
                     r_wr_y   <= w_y;
                     r_wr_col <= w_col;
                  end
               end
            end
            WRITE: begin
               r_state <= IDLE;
               r_wr_en <= 1'b0;
            end
            CLEAR: begin
               if (r_wr_x == X_LAST && r_wr_y == Y_LAST) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_wr_en <= 1'b0;
               end else if (r_wr_x == X_LAST) begin
                  r_wr_x <= '0;
                  r_wr_y <= r_wr_y + 4'd1;
               end else begin
                  r_wr_x <= r_wr_x + 4'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_wr_en <= 1'b0;
            end
         endcase
      end
   end
   assign bus.o_ack0       = r_ack0;
   assign bus.o_ack1       = r_ack1;
   assign bus.o_err        = r_err;
   assign bus.o_clear_busy = r_busy;
   assign bus.o_wr_en      = r_wr_en;
   assign bus.o_wr_x       = r_wr_x;
   assign bus.o_wr_y       = r_wr_y;
   assign bus.o_wr_r       = r_wr_col[23:16];
   assign bus.o_wr_g       = r_wr_col[15:8];
   assign bus.o_wr_b       = r_wr_col[7:0];
endmodule

// File: tb/tb_grid_write_arbiter.sv
// tb_grid_write_arbiter: directed vectors and sequences for the grid write arbiter
module tb_grid_write_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   localparam logic [23:0] CLR = 24'h53565B;
   grid_write_arbiter_if gi();
   grid_write_arbiter dut (.clk(clk), .rst(rst), .bus(gi));
   always #5 clk = ~clk;
   logic [36:0] obs;
   assign obs = {gi.o_ack0, gi.o_ack1, gi.o_err, gi.o_wr_en, gi.o_clear_busy,
                 gi.o_wr_x, gi.o_wr_y, gi.o_wr_r, gi.o_wr_g, gi.o_wr_b};
   typedef struct {
      logic        r0;
      logic        r1;
      logic [3:0]  x0;
      logic [3:0]  y0;
      logic [23:0] c0;
      logic [3:0]  x1;
      logic [3:0]  y1;
      logic [23:0] c1;
      logic        a0;
      logic        a1;
      logic        er;
      logic        we;
      logic [3:0]  ex;
      logic [3:0]  ey;
      logic [23:0] ec;
   } vec_t;
   vec_t tbl [9];
   function automatic logic [36:0] mk(input logic a0, input logic a1, input logic er, input logic we,
                                      input logic bz, input logic [3:0] x, input logic [3:0] y,
                                      input logic [23:0] c);
      return {a0, a1, er, we, bz, x, y, c};
   endfunction
   task automatic chk(input string n, input logic [36:0] act, input logic [36:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", n, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      int nwr;
      logic [3:0]  hx;
      logic [3:0]  hy;
      logic [23:0] hc;
      tbl[0] = '{1, 0, 4'd3, 4'd5, 24'hFF0000, 4'd0, 4'd0, 24'h000000, 1, 0, 0, 1, 4'd3, 4'd5, 24'hFF0000};
      tbl[1] = '{0, 1, 4'd0, 4'd0, 24'h000000, 4'd9, 4'd2, 24'h123456, 0, 1, 1, 0, 4'd3, 4'd5, 24'hFF0000};
      tbl[2] = '{1, 1, 4'd1, 4'd1, 24'h0000FF, 4'd2, 4'd2, 24'h00FF00, 1, 0, 0, 1, 4'd1, 4'd1, 24'h0000FF};
      tbl[3] = '{1, 1, 4'd1, 4'd1, 24'h0000FF, 4'd2, 4'd2, 24'h00FF00, 0, 1, 0, 1, 4'd2, 4'd2, 24'h00FF00};
      tbl[4] = '{1, 0, 4'd7, 4'd7, 24'hABCDEF, 4'd0, 4'd0, 24'h000000, 1, 0, 0, 1, 4'd7, 4'd7, 24'hABCDEF};
      tbl[5] = '{1, 0, 4'd8, 4'd0, 24'h111111, 4'd0, 4'd0, 24'h000000, 1, 0, 1, 0, 4'd7, 4'd7, 24'hABCDEF};
      tbl[6] = '{1, 1, 4'd0, 4'd0, 24'hC0FFEE, 4'd7, 4'd0, 24'hBADA55, 0, 1, 0, 1, 4'd7, 4'd0, 24'hBADA55};
      tbl[7] = '{0, 1, 4'd0, 4'd0, 24'h000000, 4'd0, 4'd15, 24'h222222, 0, 1, 1, 0, 4'd7, 4'd0, 24'hBADA55};
      tbl[8] = '{1, 1, 4'd4, 4'd4, 24'h010203, 4'd5, 4'd5, 24'h040506, 1, 0, 0, 1, 4'd4, 4'd4, 24'h010203};
      gi.i_clear_req = 0;
      gi.i_req0 = 0; gi.i_x0 = 0; gi.i_y0 = 0; gi.i_col0 = 0;
      gi.i_req1 = 0; gi.i_x1 = 0; gi.i_y1 = 0; gi.i_col1 = 0;
      repeat (2) @(posedge clk);
      #1 chk("reset", obs, '0);
      @(negedge clk) rst = 0;
      gi.i_req0 = 1; gi.i_x0 = 4'd1; gi.i_y0 = 4'd2; gi.i_col0 = 24'hAAAAAA;
      gi.i_req1 = 1; gi.i_x1 = 4'd3; gi.i_y1 = 4'd4; gi.i_col1 = 24'h555555;
      nwr = 0; hx = 0; hy = 0; hc = 0;
      for (int k = 0; k < 8; k++) begin
         tick;
         if (k % 2 == 0) begin
            hx = (k % 4 == 0) ? 4'd1 : 4'd3;
            hy = (k % 4 == 0) ? 4'd2 : 4'd4;
            hc = (k % 4 == 0) ? 24'hAAAAAA : 24'h555555;
         end
         chk($sformatf("rr%0d", k), obs, mk(k % 4 == 0, k % 4 == 2, 0, k % 2 == 0, 0, hx, hy, hc));
         nwr += int'(gi.o_wr_en);
      end
      gi.i_req0 = 0; gi.i_req1 = 0;
      chk("rr_writes", 37'(nwr), 37'd4);
      #2 rst = 1;
      #1 chk("async_rst", obs, '0);
      @(negedge clk) rst = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         gi.i_req0 = tbl[i].r0; gi.i_x0 = tbl[i].x0; gi.i_y0 = tbl[i].y0; gi.i_col0 = tbl[i].c0;
         gi.i_req1 = tbl[i].r1; gi.i_x1 = tbl[i].x1; gi.i_y1 = tbl[i].y1; gi.i_col1 = tbl[i].c1;
         tick;
         chk($sformatf("vec%0d", i), obs, mk(tbl[i].a0, tbl[i].a1, tbl[i].er, tbl[i].we, 0,
                                              tbl[i].ex, tbl[i].ey, tbl[i].ec));
         gi.i_req0 = 0; gi.i_req1 = 0;
         tick;
         chk($sformatf("vec%0d_idle", i), obs, mk(0, 0, 0, 0, 0, tbl[i].ex, tbl[i].ey, tbl[i].ec));
      end
      @(negedge clk);
      gi.i_clear_req = 1;
      gi.i_x0 = 4'd2; gi.i_y0 = 4'd6; gi.i_col0 = 24'h13579B;
      for (int i = 0; i < 64; i++) begin
         tick;
         chk($sformatf("clr%0d", i), obs, mk(0, 0, 0, 1, 1, 4'(i % 8), 4'(i / 8), CLR));
         if (i == 0) begin
            gi.i_clear_req = 0;
            gi.i_req0 = 1;
         end
      end
      tick;
      chk("clr_end", obs, mk(0, 0, 0, 0, 0, 4'd7, 4'd7, CLR));
      tick;
      chk("clr_ack", obs, mk(1, 0, 0, 1, 0, 4'd2, 4'd6, 24'h13579B));
      gi.i_req0 = 0;
      tick;
      chk("clr_ack_idle", obs, mk(0, 0, 0, 0, 0, 4'd2, 4'd6, 24'h13579B));
      @(negedge clk) gi.i_clear_req = 1;
      for (int i = 0; i < 64; i++) begin
         tick;
         chk($sformatf("held%0d", i), obs, mk(0, 0, 0, 1, 1, 4'(i % 8), 4'(i / 8), CLR));
      end
      tick;
      chk("held_gap", obs, mk(0, 0, 0, 0, 0, 4'd7, 4'd7, CLR));
      for (int i = 0; i < 20; i++) begin
         tick;
         chk($sformatf("again%0d", i), obs, mk(0, 0, 0, 1, 1, 4'(i % 8), 4'(i / 8), CLR));
         if (i == 0) gi.i_clear_req = 0;
      end
      #2 rst = 1;
      #1 chk("clr_rst", obs, '0);
      @(negedge clk) rst = 0;
      nwr = 0;
      repeat (80) begin
         tick;
         nwr += int'(gi.o_wr_en);
      end
      chk("no_strobes", 37'(nwr), 37'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
